// File: rtl/rx_char_decoder.sv
// rtl/rx_char_decoder.sv - IEEE-1355 character decoder for the DS-SE receive bit-pair stream
module rx_char_decoder #(
  parameter int DISC_TIMEOUT = 510,
  parameter int CW           = 10
) (
  input  logic       rxClk,
  input  logic       rxReset,
  input  logic [1:0] dq,
  input  logic       dqValid,
  output logic       gotNull,
  output logic       charValid,
  output logic       charIsCtl,
  output logic [7:0] charData,
  output logic       nullValid,
  output logic       errParity,
  output logic       errEsc,
  output logic       errDisc
);

  localparam logic [CW-1:0] DISC_MAX = CW'(DISC_TIMEOUT);

  // Control codes as {c1,c0}
  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_ESC = 2'b11;

  typedef enum logic [2:0] {
    S_HUNT,
    S_PF,
    S_DATA,
    S_CTL,
    S_ERR
  } state_t;

  state_t        state, state_n;

  // Last three pairs seen while hunting, minus the oldest bit, which the
  // NULL pattern treats as don't-care (it is the ESC parity bit).
  logic [4:0]    hist, hist_n;
  // XOR of the previous character's payload bits.
  logic          par_acc, par_n;
  // An ESC has been received and must be followed by FCT.
  logic          esc_flag, esc_n;
  logic [1:0]    pair_cnt, cnt_n;
  logic [7:0]    data_sr, sr_n;
  // Disconnect watchdog stays idle until the first pair after reset.
  logic          started, started_n;
  logic [CW-1:0] disc_cnt, disc_n;

  logic          got_null_n;
  logic          char_valid_n;
  logic          char_is_ctl_n;
  logic [7:0]    char_data_n;
  logic          null_valid_n;
  logic          err_par_n;
  logic          err_esc_n;
  logic          err_disc_n;

  logic          hunt_hit;
  logic          parity_ok;
  logic          esc_bad;

  // NULL in arrival order is {x,1,1,1,0,1,0,0}; dq[0] is the older bit of a pair.
  assign hunt_hit  = ({hist, dq[0], dq[1]} == 7'b1110100);
  // Odd parity over P, F and the previous character's payload.
  assign parity_ok = dq[0] ^ dq[1] ^ par_acc;
  // ESC followed by a data character (F=0).
  assign esc_bad   = esc_flag & ~dq[1];

  // State and output registers; reset wins over any pair in the same cycle.
  always_ff @(posedge rxClk) begin
    if (rxReset) begin
      state     <= S_HUNT;
      hist      <= '0;
      par_acc   <= 1'b0;
      esc_flag  <= 1'b0;
      pair_cnt  <= '0;
      data_sr   <= '0;
      started   <= 1'b0;
      disc_cnt  <= '0;
      gotNull   <= 1'b0;
      charValid <= 1'b0;
      charIsCtl <= 1'b0;
      charData  <= '0;
      nullValid <= 1'b0;
      errParity <= 1'b0;
      errEsc    <= 1'b0;
      errDisc   <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      par_acc   <= par_n;
      esc_flag  <= esc_n;
      pair_cnt  <= cnt_n;
      data_sr   <= sr_n;
      started   <= started_n;
      disc_cnt  <= disc_n;
      gotNull   <= got_null_n;
      charValid <= char_valid_n;
      charIsCtl <= char_is_ctl_n;
      charData  <= char_data_n;
      nullValid <= null_valid_n;
      errParity <= err_par_n;
      errEsc    <= err_esc_n;
      errDisc   <= err_disc_n;
    end
  end

  // Next-state decode: one pair per dqValid, watchdog on idle cycles, ERR absorbs everything.
  always_comb begin
    state_n       = state;
    hist_n        = hist;
    par_n         = par_acc;
    esc_n         = esc_flag;
    cnt_n         = pair_cnt;
    sr_n          = data_sr;
    started_n     = started;
    disc_n        = disc_cnt;
    got_null_n    = gotNull;
    char_valid_n  = 1'b0;
    char_is_ctl_n = charIsCtl;
    char_data_n   = charData;
    null_valid_n  = 1'b0;
    err_par_n     = errParity;
    err_esc_n     = errEsc;
    err_disc_n    = errDisc;

    if (state != S_ERR) begin
      if (dqValid) begin
        started_n = 1'b1;
        disc_n    = '0;
        case (state)
          S_HUNT: begin
            hist_n = {hist[2:0], dq[0], dq[1]};
            if (hunt_hit) begin
              // The matched FCT has an all-zero payload, so parity restarts at 0.
              null_valid_n = 1'b1;
              got_null_n   = 1'b1;
              par_n        = 1'b0;
              esc_n        = 1'b0;
              state_n      = S_PF;
            end
          end
          S_PF: begin
            if (!parity_ok || esc_bad) begin
              if (!parity_ok) err_par_n = 1'b1;
              if (esc_bad)    err_esc_n = 1'b1;
              state_n = S_ERR;
            end else begin
              cnt_n   = '0;
              state_n = dq[1] ? S_CTL : S_DATA;
            end
          end
          S_DATA: begin
            // Shift in from the top so the first pair lands in bits [1:0].
            sr_n = {dq[1], dq[0], data_sr[7:2]};
            if (pair_cnt == 2'd3) begin
              char_valid_n  = 1'b1;
              char_is_ctl_n = 1'b0;
              char_data_n   = sr_n;
              par_n         = ^sr_n;
              state_n       = S_PF;
            end else begin
              cnt_n = pair_cnt + 2'd1;
            end
          end
          S_CTL: begin
            par_n   = dq[0] ^ dq[1];
            state_n = S_PF;
            if (esc_flag) begin
              if (dq == CODE_FCT) begin
                null_valid_n = 1'b1;
                esc_n        = 1'b0;
              end else begin
                err_esc_n = 1'b1;
                state_n   = S_ERR;
              end
            end else if (dq == CODE_ESC) begin
              esc_n = 1'b1;
            end else begin
              char_valid_n  = 1'b1;
              char_is_ctl_n = 1'b1;
              char_data_n   = {6'b0, dq};
            end
          end
          default: ;
        endcase
      end else if (started && disc_cnt != DISC_MAX) begin
        disc_n = disc_cnt + CW'(1);
        if (disc_n == DISC_MAX) begin
          err_disc_n = 1'b1;
          state_n    = S_ERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_char_decoder.sv
// tb/tb_rx_char_decoder.sv - self-checking bench for rx_char_decoder
module tb_rx_char_decoder;

  localparam int DISC = 510;
  localparam int K_DATA = 0;
  localparam int K_FCT  = 1;
  localparam int K_EOP1 = 2;
  localparam int K_EOP2 = 3;
  localparam int K_ESC  = 4;

  typedef struct {
    int         kind;
    logic [7:0] val;
    bit         bad;
    int         gap;
  } ch_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dq = 2'b00;
  logic       dq_valid = 1'b0;
  logic       got_null, char_valid, char_is_ctl, null_valid;
  logic       err_parity, err_esc, err_disc;
  logic [7:0] char_data;

  rx_char_decoder #(.DISC_TIMEOUT(DISC), .CW(10)) dut (
    .rxClk     (clk),
    .rxReset   (rst),
    .dq        (dq),
    .dqValid   (dq_valid),
    .gotNull   (got_null),
    .charValid (char_valid),
    .charIsCtl (char_is_ctl),
    .charData  (char_data),
    .nullValid (null_valid),
    .errParity (err_parity),
    .errEsc    (err_esc),
    .errDisc   (err_disc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  // Expected behaviour, keyed by the clock edge after which it must be visible.
  int         ev_kind[int];   // 1 = NULL, 2 = data char, 3 = control char
  logic [7:0] ev_data[int];
  int gn_at = -1, ep_at = -1, ee_at = -1, ed_at = -1;

  // What the DUT actually produced in the current scenario.
  int         nv_count, cv_count, null_edge, disc_edge;
  logic [7:0] cv_data[$];
  logic       cv_ctl[$];

  int         first_pair_e, last_pair_e;
  logic [7:0] enc8;
  ch_t        cs[$];

  function automatic bit flag_on(input int at);
    return (at >= 0) && (cyc >= at);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled away from the clock edge.
  always begin
    @(posedge clk);
    #2;
    if (chk_on) begin
      int k;
      logic [5:0] ev, av;
      k  = ev_kind.exists(cyc) ? ev_kind[cyc] : 0;
      ev = {flag_on(gn_at), k == 1, k >= 2, flag_on(ep_at), flag_on(ee_at), flag_on(ed_at)};
      av = {got_null, null_valid, char_valid, err_parity, err_esc, err_disc};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL flags@%0d {gotNull,nullValid,charValid,errP,errE,errD}: got %b want %b", cyc, av, ev);
      end
      if (k >= 2) begin
        checks++;
        if ({char_is_ctl, char_data} !== {k == 3, ev_data[cyc]}) begin
          errors++;
          $display("FAIL char@%0d {isCtl,data}: got %b/%h want %b/%h", cyc, char_is_ctl, char_data, k == 3, ev_data[cyc]);
        end
      end
      if (char_valid === 1'b1) begin
        cv_count++;
        cv_data.push_back(char_data);
        cv_ctl.push_back(char_is_ctl);
      end
      if (null_valid === 1'b1) begin
        nv_count++;
        if (null_edge < 0) null_edge = cyc;
      end
      if (err_disc === 1'b1 && disc_edge < 0) disc_edge = cyc;
    end
  end

  function automatic ch_t mk(input int kind, input logic [7:0] v, input bit bad, input int gap);
    ch_t c;
    c.kind = kind;
    c.val  = v;
    c.bad  = bad;
    c.gap  = gap;
    return c;
  endfunction

  task automatic add(input int kind, input logic [7:0] v, input bit bad, input int gap);
    cs.push_back(mk(kind, v, bad, gap));
  endtask

  task automatic add_null(input int gap);
    add(K_ESC, 8'h00, 1'b0, gap);
    add(K_FCT, 8'h00, 1'b0, gap);
  endtask

  // Reset with a pair strobed alongside it; reset must win.
  task automatic do_reset();
    @(negedge clk);
    chk_on   = 0;
    rst      = 1'b1;
    dq_valid = 1'b1;
    dq       = 2'b11;
    ev_kind.delete();
    ev_data.delete();
    gn_at = -1; ep_at = -1; ee_at = -1; ed_at = -1;
    nv_count = 0; cv_count = 0; null_edge = -1; disc_edge = -1;
    cv_data.delete();
    cv_ctl.delete();
    cs.delete();
    @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    rst      = 1'b0;
    dq_valid = 1'b0;
  endtask

  // Encode the character list into pairs, derive expected events from the
  // character-level rules, then drive the pairs on their scheduled edges.
  task automatic run(input int tail);
    logic [1:0] pq[$];
    int         pe[$];
    int         last_e, e, pf_e, end_e, i;
    bit         synced, dead, esc, prev_esc, started;
    logic       prevpar;
    synced = 0; dead = 0; esc = 0; prev_esc = 0; started = 0; prevpar = 1'b0;
    last_e = cyc + 1;
    pf_e   = 0;
    foreach (cs[ci]) begin
      logic       f, p, ppar;
      logic [1:0] cd;
      logic [7:0] pl;
      int         np;
      f    = (cs[ci].kind != K_DATA);
      cd   = 2'(cs[ci].kind - 1);
      pl   = f ? {6'b0, cd} : cs[ci].val;
      np   = f ? 1 : 4;
      ppar = ^pl;
      p    = 1'b1 ^ f ^ prevpar ^ cs[ci].bad;
      for (int j = 0; j <= np; j++) begin
        e = last_e + cs[ci].gap + 1;
        if (started && !dead && cs[ci].gap >= DISC) begin
          ed_at = last_e + DISC;
          dead  = 1;
        end
        started = 1;
        pq.push_back(j == 0 ? {f, p} : {pl[2*j-1], pl[2*j-2]});
        pe.push_back(e);
        if (j == 0) pf_e = e;
        last_e = e;
      end
      if (!dead) begin
        if (!synced) begin
          if (cs[ci].kind == K_FCT && prev_esc && !cs[ci].bad) begin
            ev_kind[last_e] = 1;
            gn_at  = last_e;
            synced = 1;
            esc    = 0;
          end
        end else if (cs[ci].bad || (esc && !f)) begin
          if (cs[ci].bad) ep_at = pf_e;
          if (esc && !f)  ee_at = pf_e;
          dead = 1;
        end else if (!f) begin
          ev_kind[last_e] = 2;
          ev_data[last_e] = pl;
        end else if (esc) begin
          if (cs[ci].kind == K_FCT) begin
            ev_kind[last_e] = 1;
            esc = 0;
          end else begin
            ee_at = last_e;
            dead  = 1;
          end
        end else if (cs[ci].kind == K_ESC) begin
          esc = 1;
        end else begin
          ev_kind[last_e] = 3;
          ev_data[last_e] = pl;
        end
      end
      prev_esc = (cs[ci].kind == K_ESC);
      prevpar  = ppar;
    end
    if (started && !dead && tail >= DISC) begin
      ed_at = last_e + DISC;
      dead  = 1;
    end
    first_pair_e = pe.size() > 0 ? pe[0] : -1;
    last_pair_e  = last_e;
    enc8 = pq.size() >= 4 ? {pq[0], pq[1], pq[2], pq[3]} : 8'h00;
    end_e = last_e + tail;
    i = 0;
    while (cyc < end_e) begin
      @(negedge clk);
      if (i < pq.size() && pe[i] == cyc + 1) begin
        dq       = pq[i];
        dq_valid = 1'b1;
        i++;
      end else begin
        dq_valid = 1'b0;
        dq       = 2'($urandom);
      end
    end
    dq_valid = 1'b0;
  endtask

  initial begin
    // Lone NULL
    do_reset();
    add_null(0);
    run(5);
    chk("null_bits", enc8, 8'b10_11_10_00);
    chk("null_latency", null_edge - first_pair_e, 3);
    chk("null_count", nv_count, 1);
    chk("null_no_char", cv_count, 0);
    chk("got_null", got_null, 1);

    // NULL then data 0xA5
    do_reset();
    add_null(1);
    add(K_DATA, 8'hA5, 1'b0, 0);
    run(5);
    chk("a5_count", cv_count, 1);
    chk("a5_data", cv_data.size() > 0 ? int'(cv_data[0]) : -1, 'hA5);
    chk("a5_is_ctl", cv_ctl.size() > 0 ? int'(cv_ctl[0]) : -1, 0);

    // NULL, EOP_1, EOP_2, FCT
    do_reset();
    add_null(0);
    add(K_EOP1, 8'h00, 1'b0, 1);
    add(K_EOP2, 8'h00, 1'b0, 0);
    add(K_FCT,  8'h00, 1'b0, 2);
    run(5);
    chk("ctl_count", cv_count, 3);
    chk("ctl_code0", cv_data.size() > 2 ? int'(cv_data[0]) : -1, 1);
    chk("ctl_code1", cv_data.size() > 2 ? int'(cv_data[1]) : -1, 2);
    chk("ctl_code2", cv_data.size() > 2 ? int'(cv_data[2]) : -1, 0);

    // Parity error, later pairs ignored
    do_reset();
    add_null(0);
    add(K_DATA, 8'h3C, 1'b1, 0);
    add(K_DATA, 8'h55, 1'b0, 1);
    add(K_FCT,  8'h00, 1'b0, 0);
    add_null(0);
    run(6);
    chk("par_err", err_parity, 1);
    chk("par_no_char", cv_count, 0);
    chk("par_one_null", nv_count, 1);

    // ESC followed by EOP_1
    do_reset();
    add_null(0);
    add(K_ESC,  8'h00, 1'b0, 0);
    add(K_EOP1, 8'h00, 1'b0, 0);
    add(K_EOP2, 8'h00, 1'b0, 0);
    run(5);
    chk("esc_err", err_esc, 1);
    chk("esc_no_char", cv_count, 0);
    chk("esc_null_count", nv_count, 1);

    // Two NULLs then data
    do_reset();
    add_null(0);
    add_null(2);
    add(K_DATA, 8'h96, 1'b0, 0);
    run(5);
    chk("null2_esc", err_esc, 0);
    chk("null2_count", nv_count, 2);
    chk("null2_data", cv_data.size() > 0 ? int'(cv_data[0]) : -1, 'h96);

    // ESC followed by a data character
    do_reset();
    add_null(0);
    add(K_ESC,  8'h00, 1'b0, 0);
    add(K_DATA, 8'h0F, 1'b0, 0);
    run(5);
    chk("esc_data_err", err_esc, 1);
    chk("esc_data_par", err_parity, 0);

    // Back-to-back pairs, then disconnect
    do_reset();
    add_null(2);
    add(K_DATA, 8'h5A, 1'b0, 0);
    add(K_DATA, 8'hFF, 1'b0, 0);
    add(K_EOP2, 8'h00, 1'b0, 1);
    add(K_DATA, 8'h81, 1'b0, 3);
    run(DISC + 10);
    chk("b2b_count", cv_count, 4);
    chk("b2b_ff", cv_data.size() > 1 ? int'(cv_data[1]) : -1, 'hFF);
    chk("disc_latency", disc_edge - last_pair_e, DISC);

    // Disconnect while still hunting
    do_reset();
    add(K_DATA, 8'h00, 1'b0, 0);
    add(K_DATA, 8'h00, 1'b0, 1);
    run(DISC + 8);
    chk("hunt_disc", err_disc, 1);
    chk("hunt_no_null", got_null, 0);
    chk("hunt_disc_latency", disc_edge - last_pair_e, DISC);

    // Mixed traffic with varied spacing
    do_reset();
    add_null(0);
    for (int n = 0; n < 10; n++) begin
      add($urandom_range(0, 3), 8'($urandom), 1'b0, $urandom_range(0, 2));
    end
    add_null(1);
    add(K_DATA, 8'($urandom), 1'b0, 0);
    run(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
